// File: rtl/sram_bank_ctrl.sv
// Single-port SRAM bank behind a valid/ready request port. It handles one request at a time
// with a fixed access latency, uses byte-lane writes, and clears every word after reset.
module sram_bank_ctrl #(
  parameter  int DATA_W        = 32,
  parameter  int ADDR_W        = 17,
  parameter  int DEPTH         = 512,
  parameter  int ACCESS_CYCLES = 2,
  localparam int BE_W          = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              init_done_q, init_done_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_wr;
  logic [PTR_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;
  logic              in_range;
  logic [PTR_W-1:0]  addr_idx;

  // Range check uses the full request address so that high addresses never alias low words.
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign addr_idx = addr_q[PTR_W-1:0];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    mem_wr      = 1'b0;
    mem_idx     = ptr_q;
    mem_wdata   = '0;
    mem_wbe     = '0;

    case (state_q)
      ST_INIT: begin
        mem_wr  = 1'b1;
        mem_wbe = '1;
        ptr_d   = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          if (in_range) begin
            if (we_q) begin
              mem_wr    = 1'b1;
              mem_idx   = addr_idx;
              mem_wdata = wdata_q;
              mem_wbe   = be_q;
            end else begin
              rsp_rdata_d = mem[addr_idx];
            end
          end else begin
            rsp_err_d = 1'b1;
            if (!we_q) begin
              rsp_rdata_d = '0;
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage has no reset; a reset edge suppresses any pending write so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (mem_wr && rst) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_wbe[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule
